// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: advances the PC, resolves B / B.cond / CBZ in decode,
// and issues a one-cycle squash of the wrong-path instruction after a taken branch.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic [63:0] id_pc,
    input  logic [63:0] imm64,
    input  logic        cbz_zero,
    input  logic [3:0]  flags,
    output logic [63:0] pc,
    output logic        fetch_valid,
    output logic        id_flush,
    output logic        br_taken
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic        fetch_valid_reg, fetch_valid_next;
    logic        id_flush_reg, id_flush_next;

    // Decode classes from the top eleven opcode bits
    logic [10:0] opc;
    logic        is_b, is_bcond, is_cbz;
    logic        flag_n, flag_z, flag_v;
    logic        cond_met;
    logic        taken_cond;
    logic [63:0] target;
    logic [63:0] pc_plus4;
    logic        unused_bits;

    assign opc      = id_inst[31:21];
    assign is_b     = (opc[10:5] == 6'b000101);
    assign is_bcond = (opc[10:3] == 8'b01010100);
    assign is_cbz   = (opc[10:3] == 8'b10110100);

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_v = flags[0];

    // Carry is forwarded but none of the supported conditions consume it
    assign unused_bits = ^{flags[1], id_inst[20:4]};

    always_comb begin
        cond_met = 1'b0;
        case (id_inst[3:0])
            4'b0000: cond_met = flag_z;
            4'b0001: cond_met = !flag_z;
            4'b1010: cond_met = (flag_n == flag_v);
            4'b1011: cond_met = (flag_n != flag_v);
            4'b1100: cond_met = !flag_z && (flag_n == flag_v);
            4'b1101: cond_met = flag_z || (flag_n != flag_v);
            default: cond_met = 1'b0;
        endcase
    end

    assign taken_cond = is_b || (is_cbz && cbz_zero) || (is_bcond && cond_met);

    // Reset gating keeps br_taken quiet while the sequencer is being reset
    assign br_taken = (state_reg == ST_RUN) && id_valid && !stall && !reset && taken_cond;

    assign target   = id_pc + (imm64 << 2);
    assign pc_plus4 = pc_reg + 64'd4;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        fetch_valid_next = fetch_valid_reg;
        id_flush_next    = id_flush_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next       = ST_RUN;
                fetch_valid_next = 1'b1;
                id_flush_next    = 1'b0;
            end
            ST_RUN: begin
                if (!stall) begin
                    fetch_valid_next = 1'b1;
                    if (br_taken) begin
                        pc_next       = target;
                        id_flush_next = 1'b1;
                        state_next    = ST_FLUSH;
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            ST_FLUSH: begin
                id_flush_next = 1'b0;
                state_next    = ST_RUN;
                if (!stall) begin
                    pc_next = pc_plus4;
                end
            end
            default: begin
                state_next       = ST_BOOT;
                pc_next          = RESET_PC;
                fetch_valid_next = 1'b0;
                id_flush_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            fetch_valid_reg <= 1'b0;
            id_flush_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fetch_valid_reg <= fetch_valid_next;
            id_flush_reg    <= id_flush_next;
        end
    end

    assign pc          = pc_reg;
    assign fetch_valid = fetch_valid_reg;
    assign id_flush    = id_flush_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic [63:0] imm64;
    logic        cbz_zero;
    logic [3:0]  flags;
    logic [63:0] pc;
    logic        fetch_valid;
    logic        id_flush;
    logic        br_taken;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .imm64      (imm64),
        .cbz_zero   (cbz_zero),
        .flags      (flags),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .id_flush   (id_flush),
        .br_taken   (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase is "booting", "running" or "squashing" (0/1/2)
    logic [63:0] m_pc;
    logic        m_fv;
    logic        m_fl;
    int          m_phase;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic taken_rule(input logic [31:0] inst, input logic [3:0] fl, input logic cz);
        logic n, z, v;
        n = fl[3];
        z = fl[2];
        v = fl[0];
        if (inst[31:26] == 6'b000101) return 1'b1;
        if (inst[31:24] == 8'b10110100) return cz;
        if (inst[31:24] == 8'b01010100) begin
            case (inst[3:0])
                4'h0: return z;
                4'h1: return !z;
                4'hA: return n == v;
                4'hB: return n != v;
                4'hC: return !z && (n == v);
                4'hD: return z || (n != v);
                default: return 1'b0;
            endcase
        end
        return 1'b0;
    endfunction

    task automatic cycle(input logic rst, input logic stl, input logic vld,
                         input logic [31:0] inst, input logic [63:0] ipc,
                         input logic [63:0] imm, input logic cz, input logic [3:0] fl);
        logic exp_br;
        reset    = rst;
        stall    = stl;
        id_valid = vld;
        id_inst  = inst;
        id_pc    = ipc;
        imm64    = imm;
        cbz_zero = cz;
        flags    = fl;
        #4;
        exp_br = !rst && (m_phase == 1) && vld && !stl && taken_rule(inst, fl, cz);
        check_val("pc", pc, m_pc);
        check_val("fetch_valid", {63'd0, fetch_valid}, {63'd0, m_fv});
        check_val("id_flush", {63'd0, id_flush}, {63'd0, m_fl});
        check_val("br_taken", {63'd0, br_taken}, {63'd0, exp_br});
        $display("cyc rst=%0b stall=%0b vld=%0b inst=%h pc=%h br=%0b flush=%0b",
                 rst, stl, vld, inst, pc, br_taken, id_flush);
        if (rst) begin
            m_pc = RESET_PC; m_fv = 1'b0; m_fl = 1'b0; m_phase = 0;
        end else if (m_phase == 0) begin
            m_fv = 1'b1; m_fl = 1'b0; m_phase = 1;
        end else if (m_phase == 1) begin
            if (!stl) begin
                m_fv = 1'b1;
                if (exp_br) begin
                    m_pc = ipc + imm * 4;
                    m_fl = 1'b1;
                    m_phase = 2;
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end else begin
            m_fl = 1'b0;
            m_phase = 1;
            if (!stl) m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP_INST  = 32'hD503201F;
    localparam logic [31:0] B_12      = {6'b000101, 26'd12};
    localparam logic [31:0] BLT_M7    = {8'b01010100, 19'h7FFF9, 1'b0, 4'b1011};
    localparam logic [31:0] CBZ_6     = {8'b10110100, 19'd6, 5'd1};
    localparam logic [31:0] ADDI_INST = 32'h91000421;
    localparam logic [31:0] LDUR_INST = 32'hF8400020;
    localparam logic [31:0] STUR_INST = 32'hF8000020;

    initial begin
        logic [63:0] saved_pc;
        logic [31:0] r;
        logic [31:0] rinst;
        logic [63:0] rimm;
        reset = 1'b1; stall = 1'b0; id_valid = 1'b0; id_inst = NOP_INST;
        id_pc = 64'd0; imm64 = 64'd0; cbz_zero = 1'b0; flags = 4'd0;
        @(posedge clk);
        #1;
        m_pc = RESET_PC; m_fv = 1'b0; m_fl = 1'b0; m_phase = 0;

        // Reset, boot and free-running fetch
        cycle(1, 0, 0, NOP_INST, 0, 0, 0, 0);
        cycle(0, 1, 0, NOP_INST, 0, 0, 0, 0);
        check_val("boot_pc_held", pc, 64'h0);
        check_val("boot_fv_rise", {63'd0, fetch_valid}, 64'd1);
        cycle(0, 0, 0, NOP_INST, 0, 0, 0, 0);
        cycle(0, 0, 0, NOP_INST, 0, 0, 0, 0);
        cycle(0, 0, 0, NOP_INST, 0, 0, 0, 0);
        check_val("run_pc_12", pc, 64'd12);

        // Unconditional branch
        cycle(0, 0, 1, B_12, 64'h100, 64'd12, 0, 0);
        check_val("b_target", pc, 64'h130);
        check_val("b_flush", {63'd0, id_flush}, 64'd1);
        cycle(0, 0, 1, B_12, 64'h100, 64'd12, 0, 0);
        check_val("b_after_flush", pc, 64'h134);

        // B.LT taken, then not taken
        cycle(0, 0, 1, BLT_M7, 64'h40, 64'hFFFF_FFFF_FFFF_FFF9, 0, 4'b1000);
        check_val("blt_taken", pc, 64'h24);
        cycle(0, 0, 0, NOP_INST, 0, 0, 0, 0);
        cycle(0, 0, 1, BLT_M7, 64'h40, 64'hFFFF_FFFF_FFFF_FFF9, 0, 4'b1001);
        check_val("blt_not_taken", pc, 64'h2C);

        // CBZ held across a stall, resolved on release
        cycle(0, 1, 1, CBZ_6, 64'h200, 64'd6, 1, 0);
        cycle(0, 1, 1, CBZ_6, 64'h200, 64'd6, 1, 0);
        cycle(0, 1, 1, CBZ_6, 64'h200, 64'd6, 1, 0);
        check_val("cbz_stall_hold", pc, 64'h2C);
        cycle(0, 0, 1, CBZ_6, 64'h200, 64'd6, 1, 0);
        check_val("cbz_taken", pc, 64'h218);
        cycle(0, 0, 0, NOP_INST, 0, 0, 0, 0);

        // Wrap-around target, then reset during the squash cycle
        cycle(0, 0, 1, B_12, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 0, 0);
        check_val("wrap_target", pc, 64'h10);
        cycle(1, 0, 1, B_12, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 0, 0);
        check_val("rst_in_flush_pc", pc, RESET_PC);
        check_val("rst_in_flush_fl", {63'd0, id_flush}, 64'd0);
        cycle(0, 0, 1, B_12, 64'h500, 64'd8, 0, 0);
        cycle(0, 0, 0, NOP_INST, 0, 0, 0, 0);

        // Non-branch instructions only advance the PC
        saved_pc = m_pc;
        cycle(0, 0, 1, ADDI_INST, 64'h300, 64'd40, 1, 4'hF);
        cycle(0, 0, 1, LDUR_INST, 64'h304, 64'd40, 1, 4'hF);
        cycle(0, 0, 1, STUR_INST, 64'h308, 64'd40, 1, 4'hF);
        check_val("nonbranch_adv", pc, saved_pc + 64'd12);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            rimm = {{32{r[31]}}, r};
            case ($urandom_range(0, 4))
                0: rinst = {6'b000101, r[25:0]};
                1: rinst = {8'b01010100, r[23:5], 1'b0, 4'($urandom_range(0, 15))};
                2: rinst = {8'b10110100, r[23:0]};
                3: rinst = ADDI_INST;
                default: rinst = $urandom;
            endcase
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), rinst, {$urandom, $urandom}, rimm,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
